// File: rtl/grf_write_arbiter_if.sv
// Bus bundle for grf_write_arbiter: writeback, long-latency result, issue/check
// and GRF write-port signals. The arbiter connects through the slave modport.
interface grf_write_arbiter_if;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic [4:0]  chk_addr1;
   logic [4:0]  chk_addr2;
   logic        busy1;
   logic        busy2;
   logic        wb_hold;
   logic        grf_we;
   logic [4:0]  grf_wreg;
   logic [31:0] grf_wdata;

   modport slave (
      input  wb_we, wb_addr, wb_data,
      input  lu_valid, lu_addr, lu_data,
      input  iss_valid, iss_addr, chk_addr1, chk_addr2,
      output lu_ready, busy1, busy2, wb_hold,
      output grf_we, grf_wreg, grf_wdata
   );

   modport master (
      output wb_we, wb_addr, wb_data,
      output lu_valid, lu_addr, lu_data,
      output iss_valid, iss_addr, chk_addr1, chk_addr2,
      input  lu_ready, busy1, busy2, wb_hold,
      input  grf_we, grf_wreg, grf_wdata
   );
endinterface

// File: rtl/grf_write_arbiter.sv
// Shares the GRF write port between writeback (always wins) and a FIFO of
// long-latency results; keeps a pending scoreboard and a starvation counter.
// Optional: define GRFARB_BYPASS_EN to let a result skip an empty FIFO.
module grf_write_arbiter #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned STARVE = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   grf_write_arbiter_if.slave  bus
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = 8;
   localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
   localparam logic [CW-1:0] STARVE_C = CW'(STARVE);

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } result_t;

   result_t       fifo_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   sb_q, sb_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          lu_ready_q, lu_ready_d;
   logic          wb_hold_q, wb_hold_d;

   logic          wb_eff;
   logic          fifo_empty;
   logic          pop;
   logic          push;
   logic          bypass;
   logic [PW-1:0] count;
   logic [PW-1:0] count_nxt;
   result_t       head;

   logic          grf_we_c;
   logic [4:0]    grf_wreg_c;
   logic [31:0]   grf_wdata_c;

   assign wb_eff     = bus.wb_we && (bus.wb_addr != 5'd0);
   assign count      = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (count == '0);
   assign head       = fifo_q[rd_ptr_q[AW-1:0]];
   assign pop        = reset_n && !fifo_empty && !wb_eff;

`ifdef GRFARB_BYPASS_EN
   // A result arriving to an idle port with nothing queued goes straight through.
   assign bypass = reset_n && fifo_empty && !wb_eff && bus.lu_valid &&
                   lu_ready_q && (bus.lu_addr != 5'd0);
`else
   assign bypass = 1'b0;
`endif

   // $0 results are accepted but never stored.
   assign push = bus.lu_valid && lu_ready_q && (bus.lu_addr != 5'd0) && !bypass;

   // GRF port select: writeback, then FIFO head, then bypassed result.
   always_comb begin
      grf_we_c    = 1'b0;
      grf_wreg_c  = 5'd0;
      grf_wdata_c = 32'd0;
      if (reset_n) begin
         if (wb_eff) begin
            grf_we_c    = 1'b1;
            grf_wreg_c  = bus.wb_addr;
            grf_wdata_c = bus.wb_data;
         end else if (!fifo_empty) begin
            grf_we_c    = 1'b1;
            grf_wreg_c  = head.addr;
            grf_wdata_c = head.data;
         end else if (bypass) begin
            grf_we_c    = 1'b1;
            grf_wreg_c  = bus.lu_addr;
            grf_wdata_c = bus.lu_data;
         end
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_nxt  = wr_ptr_d - rd_ptr_d;
      lu_ready_d = (count_nxt != DEPTH_C);

      // Clears first so a same-cycle issue to the same register wins.
      sb_d = sb_q;
      if (pop) begin
         sb_d[head.addr] = 1'b0;
      end
      if (bypass) begin
         sb_d[bus.lu_addr] = 1'b0;
      end
      if (bus.iss_valid && (bus.iss_addr != 5'd0)) begin
         sb_d[bus.iss_addr] = 1'b1;
      end

      starve_d = '0;
      if (!fifo_empty && !pop) begin
         starve_d = (starve_q == STARVE_C) ? starve_q : starve_q + CW'(1);
      end
      wb_hold_d = (starve_d == STARVE_C);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sb_q       <= '0;
         starve_q   <= '0;
         lu_ready_q <= 1'b0;
         wb_hold_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sb_q       <= sb_d;
         starve_q   <= starve_d;
         lu_ready_q <= lu_ready_d;
         wb_hold_q  <= wb_hold_d;
      end
   end

   // Storage needs no reset: validity is carried by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= '{addr: bus.lu_addr, data: bus.lu_data};
      end
   end

   assign bus.lu_ready  = lu_ready_q;
   assign bus.wb_hold   = wb_hold_q;
   assign bus.busy1     = sb_q[bus.chk_addr1] && (bus.chk_addr1 != 5'd0);
   assign bus.busy2     = sb_q[bus.chk_addr2] && (bus.chk_addr2 != 5'd0);
   assign bus.grf_we    = grf_we_c;
   assign bus.grf_wreg  = grf_wreg_c;
   assign bus.grf_wdata = grf_wdata_c;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed plus randomized bench for grf_write_arbiter against a queue-based
// reference model of the arbitration, scoreboard and starvation rules.
module tb_grf_write_arbiter;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned STARVE = 8;
`ifdef GRFARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic clk;
   logic reset_n;
   grf_write_arbiter_if bus();

   grf_write_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_chk  = 0;
   int    n_fail = 0;
   ent_t  mq[$];
   bit [31:0] m_sb;
   int    m_starve;
   bit    m_hold;
   bit    m_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
      bus.lu_valid = 1'b0; bus.lu_addr = 5'd0; bus.lu_data = 32'd0;
      bus.iss_valid = 1'b0; bus.iss_addr = 5'd0;
   endtask

   // One clock: check outputs against the model, then advance the model.
   task automatic cycle();
      bit   wbe, byp, pop, push;
      int   sz;
      logic ew;
      logic [4:0] ea;
      logic [31:0] ed;
      wbe = bus.wb_we && (bus.wb_addr != 0);
      sz  = mq.size();
      byp = BYP && !wbe && sz == 0 && bus.lu_valid && m_ready && bus.lu_addr != 0;
      ew = 1'b0; ea = 5'd0; ed = 32'd0;
      if (wbe) begin
         ew = 1'b1; ea = bus.wb_addr; ed = bus.wb_data;
      end else if (sz > 0) begin
         ew = 1'b1; ea = mq[0].a; ed = mq[0].d;
      end else if (byp) begin
         ew = 1'b1; ea = bus.lu_addr; ed = bus.lu_data;
      end
      #1;
      chk("grf_we", 32'(bus.grf_we), 32'(ew));
      if (ew) begin
         chk("grf_wreg", 32'(bus.grf_wreg), 32'(ea));
         chk("grf_wdata", bus.grf_wdata, ed);
      end
      chk("lu_ready", 32'(bus.lu_ready), 32'(m_ready));
      chk("wb_hold", 32'(bus.wb_hold), 32'(m_hold));
      chk("busy1", 32'(bus.busy1), 32'(m_sb[bus.chk_addr1] && bus.chk_addr1 != 0));
      chk("busy2", 32'(bus.busy2), 32'(m_sb[bus.chk_addr2] && bus.chk_addr2 != 0));
      pop  = !wbe && sz > 0;
      push = bus.lu_valid && m_ready && bus.lu_addr != 0 && !byp;
      if (pop) begin
         m_sb[mq[0].a] = 1'b0;
         mq.delete(0);
      end
      if (byp) m_sb[bus.lu_addr] = 1'b0;
      if (push) mq.push_back('{a: bus.lu_addr, d: bus.lu_data});
      if (bus.iss_valid && bus.iss_addr != 0) m_sb[bus.iss_addr] = 1'b1;
      if (sz > 0 && !pop) m_starve = (m_starve >= int'(STARVE)) ? int'(STARVE) : m_starve + 1;
      else m_starve = 0;
      m_hold  = (m_starve == int'(STARVE));
      m_ready = (mq.size() < int'(DEPTH));
      @(posedge clk);
      @(negedge clk);
   endtask

   // One cycle of reset with writeback still requested, released at the negedge.
   task automatic do_reset();
      reset_n = 1'b0;
      bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h1234;
      #1;
      chk("rst_grf_we", 32'(bus.grf_we), 32'd0);
      chk("rst_lu_ready", 32'(bus.lu_ready), 32'd0);
      chk("rst_busy1", 32'(bus.busy1), 32'd0);
      chk("rst_busy2", 32'(bus.busy2), 32'd0);
      chk("rst_wb_hold", 32'(bus.wb_hold), 32'd0);
      mq.delete();
      m_sb = '0; m_starve = 0; m_hold = 1'b0; m_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idle_inputs();
   endtask

   task automatic push_lu(input logic [4:0] a, input logic [31:0] d);
      bus.lu_valid = 1'b1; bus.lu_addr = a; bus.lu_data = d;
   endtask

   initial begin
      reset_n = 1'b1;
      idle_inputs();
      bus.chk_addr1 = 5'd5; bus.chk_addr2 = 5'd9;
      @(negedge clk);
      do_reset();
      cycle();                                   // lu_ready rises at this edge

      // Reset mid-queue
      bus.wb_we = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'h11;
      for (int i = 0; i < 3; i++) begin
         push_lu(5'(10 + i), 32'(100 + i));
         cycle();
      end
      do_reset();
      cycle();
      chk("post_rst_ready", 32'(bus.lu_ready), 32'd1);
      chk("post_rst_idle_we", 32'(bus.grf_we), 32'd0);

      // Contention: writeback $3 beats result $5; $5 lands next cycle
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd5;
      cycle();
      idle_inputs();
      bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hAAAA;
      push_lu(5'd5, 32'h5555);
      cycle();
      idle_inputs();
      #1;
      chk("cont_c1_reg", 32'(bus.grf_wreg), 32'd5);
      chk("cont_c1_busy", 32'(bus.busy1), 32'd1);
      cycle();
      chk("cont_c2_busy", 32'(bus.busy1), 32'd0);
      cycle();

      // Full: writeback holds the port while DEPTH+2 results are offered
      bus.wb_we = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h22;
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         push_lu(5'(20 + i), 32'(32'hF0 + i));
         cycle();
      end
      chk("full_ready", 32'(bus.lu_ready), 32'd0);
      idle_inputs();
      for (int i = 0; i < int'(DEPTH) + 1; i++) cycle();

      // Starvation: one entry blocked for STARVE cycles, then drained
      push_lu(5'd4, 32'h44);
      bus.wb_we = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h66;
      cycle();
      bus.lu_valid = 1'b0;
      for (int i = 0; i < int'(STARVE); i++) cycle();
      chk("starve_hold", 32'(bus.wb_hold), 32'd1);
      cycle();                                   // writeback still wins under hold
      bus.wb_we = 1'b0;
      cycle();
      chk("starve_release", 32'(bus.wb_hold), 32'd0);
      cycle();

      // $0 handling
      bus.wb_we = 1'b1; bus.wb_addr = 5'd1;
      push_lu(5'd7, 32'h77);
      cycle();
      bus.wb_addr = 5'd0; bus.lu_valid = 1'b0;
      cycle();
      idle_inputs();
      push_lu(5'd0, 32'hDEAD);
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
      bus.chk_addr2 = 5'd0;
      cycle();
      idle_inputs();
      cycle();
      chk("zero_busy", 32'(bus.busy2), 32'd0);

      // Scoreboard race: issue to $9 in the cycle its head write clears it
      bus.chk_addr2 = 5'd9;
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
      cycle();
      idle_inputs();
      bus.wb_we = 1'b1; bus.wb_addr = 5'd1;
      push_lu(5'd9, 32'h99);
      cycle();
      idle_inputs();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
      cycle();
      idle_inputs();
      cycle();
      chk("race_busy", 32'(bus.busy2), 32'd1);

      // Randomized traffic with one asynchronous reset in the middle
      for (int n = 0; n < 600; n++) begin
         if (n == 300) do_reset();
         bus.wb_we     = ($urandom_range(0, 99) < 45);
         bus.wb_addr   = 5'($urandom_range(0, 31));
         bus.wb_data   = $urandom;
         bus.lu_valid  = ($urandom_range(0, 99) < 40);
         bus.lu_addr   = 5'($urandom_range(0, 31));
         bus.lu_data   = $urandom;
         bus.iss_addr  = 5'($urandom_range(0, 31));
         bus.iss_valid = ($urandom_range(0, 99) < 30) && !m_sb[bus.iss_addr];
         bus.chk_addr1 = 5'($urandom_range(0, 31));
         bus.chk_addr2 = 5'($urandom_range(0, 31));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
